// File: rtl/npu_seq_ctrl.sv
// rtl/npu_seq_ctrl.sv - host-bus front end and N-stage start/done sequencer for the NPU pipeline
// Optional stage watchdog enabled by defining NPU_SEQ_WDT_EN.
module npu_seq_ctrl #(
  parameter int N_BANKS    = 5,
  parameter int N_STAGES   = 3,
  parameter int SEL_W      = 3,
  parameter int IDX_W      = 12,
  parameter int DATA_W     = 8,
  parameter int RES_W      = 24,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_we,
  input  logic [SEL_W+IDX_W-1:0] i_addr,
  input  logic [31:0]            i_w_data,
  output logic [31:0]            o_r_data,
  output logic                   o_r_valid,
  output logic [N_BANKS-1:0]     o_bank_we,
  output logic [IDX_W-1:0]       o_bank_idx,
  output logic [DATA_W-1:0]      o_bank_data,
  output logic [N_STAGES-1:0]    o_stage_start,
  input  logic [N_STAGES-1:0]    i_stage_done,
  input  logic [RES_W-1:0]       i_result_in,
  output logic                   o_busy,
  output logic                   o_irq
);

  localparam int KW = $clog2(N_STAGES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [KW-1:0]     r_k;
  logic [RES_W-1:0]  r_result;
  logic              r_done, r_wr_err, r_timeout, r_irq, r_r_valid;
  logic [31:0]       r_r_data;
  logic [N_BANKS-1:0] r_bank_we;
  logic [IDX_W-1:0]  r_bank_idx;
  logic [DATA_W-1:0] r_bank_data;

  logic [SEL_W-1:0]  w_sel;
  logic [IDX_W-1:0]  w_idx;
  logic              w_ctrl_wr, w_clear, w_trig, w_bank_wr, w_busy, w_kdone, w_last;
  logic              w_finish, w_advance, w_abort, w_wdt_expire;
  logic [31:0]       w_status, w_rd_mux;

  assign w_sel     = i_addr[SEL_W+IDX_W-1:IDX_W];
  assign w_idx     = i_addr[IDX_W-1:0];
  assign w_ctrl_wr = i_en & i_we & (w_sel == SEL_W'(N_BANKS));
  assign w_clear   = w_ctrl_wr & (w_idx == IDX_W'(0));
  assign w_trig    = w_ctrl_wr & (w_idx == IDX_W'(1));
  assign w_bank_wr = i_en & i_we & (w_sel < SEL_W'(N_BANKS));
  assign w_busy    = (r_state == S_START) || (r_state == S_WAIT);
  assign w_kdone   = i_stage_done[r_k];
  assign w_last    = (r_k == KW'(N_STAGES - 1));

`ifdef NPU_SEQ_WDT_EN
  logic [31:0] r_wdt;

  // Counts cycles since the current stage's start pulse (the start cycle counts as 1).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                   r_wdt <= '0;
    else if (r_state == S_START) r_wdt <= 32'd1;
    else if (r_state == S_WAIT)  r_wdt <= r_wdt + 32'd1;
  end

  assign w_wdt_expire = (r_state == S_WAIT) && (r_wdt == 32'(WDT_CYCLES - 1));
`else
  logic w_unused_wdt;
  assign w_unused_wdt = (WDT_CYCLES == 0);
  assign w_wdt_expire = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_finish  = 1'b0;
    w_advance = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (w_trig) w_next = S_START;
      S_START:        w_next = S_WAIT;
      S_WAIT: begin
        if (w_kdone) begin
          if (w_last) begin
            w_next   = S_DONE;
            w_finish = 1'b1;
          end else begin
            w_next    = S_START;
            w_advance = 1'b1;
          end
        end else if (w_wdt_expire) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Soft clear overrides completion, advance and watchdog abort.
    if (w_clear) begin
      w_next    = S_IDLE;
      w_finish  = 1'b0;
      w_advance = 1'b0;
      w_abort   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  assign w_status = {16'b0, 8'(r_k), 4'b0, r_timeout, r_wr_err, r_done, w_busy};

  always_comb begin
    w_rd_mux = '0;
    if (w_sel == SEL_W'(N_BANKS) && w_idx == IDX_W'(2))
      w_rd_mux = {{(32-RES_W){r_result[RES_W-1]}}, r_result};
    else if (w_sel == SEL_W'(N_BANKS) && w_idx == IDX_W'(3))
      w_rd_mux = w_status;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k         <= '0;
      r_result    <= '0;
      r_done      <= 1'b0;
      r_wr_err    <= 1'b0;
      r_timeout   <= 1'b0;
      r_irq       <= 1'b0;
      r_r_valid   <= 1'b0;
      r_r_data    <= '0;
      r_bank_we   <= '0;
      r_bank_idx  <= '0;
      r_bank_data <= '0;
    end else begin
      r_bank_we <= '0;
      r_irq     <= 1'b0;
      r_r_valid <= 1'b0;
      if (w_bank_wr && !w_busy) begin
        r_bank_we   <= N_BANKS'(1) << w_sel;
        r_bank_idx  <= w_idx;
        r_bank_data <= i_w_data[DATA_W-1:0];
      end
      if (w_bank_wr && w_busy) r_wr_err <= 1'b1;
      if (i_en && !i_we) begin
        r_r_valid <= 1'b1;
        r_r_data  <= w_rd_mux;
      end
      if (w_clear) begin
        r_k       <= '0;
        r_result  <= '0;
        r_done    <= 1'b0;
        r_wr_err  <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (w_trig && !w_busy) begin
          r_done <= 1'b0;
          r_k    <= '0;
        end
        if (w_advance) r_k <= r_k + KW'(1);
        if (w_finish) begin
          r_result <= i_result_in;
          r_done   <= 1'b1;
          r_irq    <= 1'b1;
        end
        if (w_abort) begin
          r_timeout <= 1'b1;
          r_irq     <= 1'b1;
        end
      end
    end
  end

  logic w_unused_data;
  assign w_unused_data = &{1'b0, i_w_data[31:DATA_W]};

  assign o_stage_start = (r_state == S_START) ? (N_STAGES'(1) << r_k) : '0;
  assign o_busy        = w_busy;
  assign o_irq         = r_irq;
  assign o_r_data      = r_r_data;
  assign o_r_valid     = r_r_valid;
  assign o_bank_we     = r_bank_we;
  assign o_bank_idx    = r_bank_idx;
  assign o_bank_data   = r_bank_data;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// tb/tb_npu_seq_ctrl.sv - directed self-checking bench for npu_seq_ctrl
// Watchdog scenario is built only when NPU_SEQ_WDT_EN is defined.
module tb_npu_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_we = 1'b0;
  logic [14:0] i_addr = '0;
  logic [31:0] i_w_data = '0;
  logic [31:0] o_r_data;
  logic        o_r_valid;
  logic [4:0]  o_bank_we;
  logic [11:0] o_bank_idx;
  logic [7:0]  o_bank_data;
  logic [2:0]  o_stage_start;
  logic [2:0]  i_stage_done = '0;
  logic [23:0] i_result_in = '0;
  logic        o_busy;
  logic        o_irq;

  int checks = 0;
  int failures = 0;

  npu_seq_ctrl #(.WDT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_we(i_we), .i_addr(i_addr),
    .i_w_data(i_w_data), .o_r_data(o_r_data), .o_r_valid(o_r_valid),
    .o_bank_we(o_bank_we), .o_bank_idx(o_bank_idx), .o_bank_data(o_bank_data),
    .o_stage_start(o_stage_start), .i_stage_done(i_stage_done),
    .i_result_in(i_result_in), .o_busy(o_busy), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic host_wr(input logic [2:0] sel, input logic [11:0] idx, input logic [31:0] d);
    i_en = 1'b1; i_we = 1'b1; i_addr = {sel, idx}; i_w_data = d;
    tick();
    i_en = 1'b0; i_we = 1'b0;
  endtask

  task automatic host_rd(input logic [2:0] sel, input logic [11:0] idx,
                         output logic [31:0] d, output logic v);
    i_en = 1'b1; i_we = 1'b0; i_addr = {sel, idx};
    tick();
    d = o_r_data; v = o_r_valid;
    i_en = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
    checks++; if (o_stage_start !== 3'b000) begin failures++; $display("FAIL reset_start got=%b exp=000", o_stage_start); end
    checks++; if (o_bank_we !== 5'b0) begin failures++; $display("FAIL reset_bank_we got=%b exp=0", o_bank_we); end
    checks++; if ({o_r_valid, o_r_data} !== 33'b0) begin failures++; $display("FAIL reset_rdata got=%b/%h exp=0/0", o_r_valid, o_r_data); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_bank_write();
    host_wr(3'd3, 12'd1319, 32'h1234_56A5);
    checks++; if (o_bank_we !== 5'b01000) begin failures++; $display("FAIL bank_we got=%b exp=01000", o_bank_we); end
    checks++; if (o_bank_idx !== 12'd1319) begin failures++; $display("FAIL bank_idx got=%0d exp=1319", o_bank_idx); end
    checks++; if (o_bank_data !== 8'hA5) begin failures++; $display("FAIL bank_data got=%h exp=a5", o_bank_data); end
    tick();
    checks++; if (o_bank_we !== 5'b0) begin failures++; $display("FAIL bank_we_pulse got=%b exp=0", o_bank_we); end
    host_wr(3'd6, 12'd5, 32'hFF);
    checks++; if (o_bank_we !== 5'b0) begin failures++; $display("FAIL unmapped_wr got=%b exp=0", o_bank_we); end
  endtask

  task automatic test_full_sequence();
    logic [31:0] d;
    logic v;
    logic [2:0] exp_start;
    host_wr(3'd5, 12'd1, 32'h0);
    for (int c = 1; c <= 14; c++) begin
      exp_start = (c == 1) ? 3'b001 : (c == 6) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
      checks++; if (o_stage_start !== exp_start) begin failures++; $display("FAIL seq_start c=%0d got=%b exp=%b", c, o_stage_start, exp_start); end
      checks++; if (o_irq !== (c == 13)) begin failures++; $display("FAIL seq_irq c=%0d got=%b exp=%b", c, o_irq, c == 13); end
      checks++; if (o_busy !== (c <= 12)) begin failures++; $display("FAIL seq_busy c=%0d got=%b exp=%b", c, o_busy, c <= 12); end
      i_stage_done = (c == 5) ? 3'b001 : (c == 8) ? 3'b010 : (c == 12) ? 3'b100 : 3'b000;
      i_result_in = (c == 12) ? 24'hFFFFFB : 24'h0;
      tick();
      i_stage_done = '0;
      i_result_in = '0;
    end
    host_rd(3'd5, 12'd2, d, v);
    checks++; if (d !== 32'hFFFF_FFFB || v !== 1'b1) begin failures++; $display("FAIL result_rd got=%h/%b exp=fffffffb/1", d, v); end
    host_rd(3'd5, 12'd3, d, v);
    checks++; if (d !== 32'h0000_0202) begin failures++; $display("FAIL status_done got=%h exp=00000202", d); end
    tick();
    checks++; if (o_r_valid !== 1'b0 || o_r_data !== 32'h0000_0202) begin failures++; $display("FAIL rdata_hold got=%h/%b exp=00000202/0", o_r_data, o_r_valid); end
    host_rd(3'd1, 12'd2, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL other_rd got=%h exp=0", d); end
  endtask

  task automatic test_write_lock();
    logic [31:0] d;
    logic v;
    host_wr(3'd5, 12'd1, 32'h0);
    host_wr(3'd0, 12'd5, 32'h77);
    checks++; if (o_bank_we !== 5'b0) begin failures++; $display("FAIL lock_no_we got=%b exp=0", o_bank_we); end
    host_rd(3'd5, 12'd3, d, v);
    checks++; if (d !== 32'h0000_0005) begin failures++; $display("FAIL lock_status got=%h exp=00000005", d); end
    host_wr(3'd5, 12'd0, 32'h0);
    checks++; if (o_busy !== 1'b0 || o_irq !== 1'b0) begin failures++; $display("FAIL clear_idle got=%b%b exp=00", o_busy, o_irq); end
    host_rd(3'd5, 12'd3, d, v);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL clear_status got=%h exp=00000000", d); end
  endtask

  task automatic test_trigger_stray();
    logic [31:0] d;
    logic v;
    host_wr(3'd5, 12'd1, 32'h0);
    tick();
    host_wr(3'd5, 12'd1, 32'h0);
    checks++; if (o_stage_start !== 3'b000 || o_busy !== 1'b1) begin failures++; $display("FAIL wait_trigger got=%b/%b exp=000/1", o_stage_start, o_busy); end
    i_stage_done = 3'b100;
    tick();
    i_stage_done = '0;
    checks++; if (o_stage_start !== 3'b000) begin failures++; $display("FAIL stray_done got=%b exp=000", o_stage_start); end
    host_rd(3'd5, 12'd3, d, v);
    checks++; if (d !== 32'h0000_0001) begin failures++; $display("FAIL stray_status got=%h exp=00000001", d); end
    i_stage_done = 3'b001;
    tick();
    i_stage_done = '0;
    checks++; if (o_stage_start !== 3'b010) begin failures++; $display("FAIL k0_advance got=%b exp=010", o_stage_start); end
    tick();
    i_stage_done = 3'b010;
    host_wr(3'd5, 12'd0, 32'h0);
    i_stage_done = '0;
    checks++; if (o_busy !== 1'b0 || o_stage_start !== 3'b000 || o_irq !== 1'b0) begin failures++; $display("FAIL clear_wins got=%b/%b/%b exp=0/000/0", o_busy, o_stage_start, o_irq); end
    tick();
    checks++; if (o_irq !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL clear_stay got=%b/%b exp=0/0", o_irq, o_busy); end
  endtask

  task automatic test_async_reset();
    host_wr(3'd5, 12'd1, 32'h0);
    checks++; if (o_stage_start !== 3'b001) begin failures++; $display("FAIL pre_rst_start got=%b exp=001", o_stage_start); end
    #2;
    i_rst = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b0 || o_stage_start !== 3'b000 || o_irq !== 1'b0) begin failures++; $display("FAIL async_rst got=%b/%b/%b exp=0/000/0", o_busy, o_stage_start, o_irq); end
    tick();
    i_rst = 1'b0;
    tick();
  endtask

`ifdef NPU_SEQ_WDT_EN
  task automatic test_watchdog();
    logic [31:0] d;
    logic v;
    host_wr(3'd5, 12'd1, 32'h0);
    tick();
    i_stage_done = 3'b001;
    tick();
    i_stage_done = '0;
    checks++; if (o_stage_start !== 3'b010) begin failures++; $display("FAIL wdt_start1 got=%b exp=010", o_stage_start); end
    for (int j = 1; j <= 17; j++) begin
      tick();
      checks++; if (o_irq !== (j == 16)) begin failures++; $display("FAIL wdt_irq j=%0d got=%b exp=%b", j, o_irq, j == 16); end
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL wdt_busy got=%b exp=0", o_busy); end
    host_rd(3'd5, 12'd3, d, v);
    checks++; if (d !== 32'h0000_0108) begin failures++; $display("FAIL wdt_status got=%h exp=00000108", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_bank_write();
    test_full_sequence();
    test_write_lock();
    test_trigger_stray();
    test_async_reset();
`ifdef NPU_SEQ_WDT_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
